// File: rtl/arm_mc_controller.sv
// Multicycle ARM control unit: instruction decode, condition flags and the
// per-state datapath enables/selects for DP, LDR/STR, B and BL.
module arm_mc_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic [19:0] Instr,
    input  logic [3:0]  ALUFlags,
    output logic        PCWrite,
    output logic        MemWrite,
    output logic        RegWrite,
    output logic        IRWrite,
    output logic        AdrSrc,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ALUControl,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ImmSrc,
    output logic [1:0]  RegSrc,
    output logic        LinkWrite
);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
        S_EXECR, S_EXECI, S_ALUWB, S_LINK, S_BRANCH
    } state_t;

    state_t     state, state_next, state_eff;
    logic [3:0] cond, rd, flags;
    logic [1:0] op;
    logic [5:0] funct;
    logic       cond_ex, cond_ex_live, cond_q;
    logic       cmd_ok, cmd_arith;
    logic [1:0] cmd_alu;
    logic       unused_rn;

    assign cond      = Instr[19:16];
    assign op        = Instr[15:14];
    assign funct     = Instr[13:8];
    assign rd        = Instr[3:0];
    assign unused_rn = ^Instr[7:4];

    assign ImmSrc = op;
    assign RegSrc = (op == 2'b10) ? 2'b01 : (op == 2'b01) ? 2'b10 : 2'b00;

    always_comb begin
        cmd_ok    = 1'b1;
        cmd_arith = 1'b0;
        cmd_alu   = 2'b00;
        unique case (funct[4:1])
            4'b0100: begin cmd_alu = 2'b00; cmd_arith = 1'b1; end
            4'b0010: begin cmd_alu = 2'b01; cmd_arith = 1'b1; end
            4'b0000: cmd_alu = 2'b10;
            4'b1100: cmd_alu = 2'b11;
            default: cmd_ok = 1'b0;
        endcase
    end

    // flags = {N,Z,C,V}
    always_comb begin
        unique case (cond)
            4'b0000: cond_ex_live = flags[2];
            4'b0001: cond_ex_live = ~flags[2];
            4'b0010: cond_ex_live = flags[1];
            4'b0011: cond_ex_live = ~flags[1];
            4'b0100: cond_ex_live = flags[3];
            4'b0101: cond_ex_live = ~flags[3];
            4'b0110: cond_ex_live = flags[0];
            4'b0111: cond_ex_live = ~flags[0];
            4'b1000: cond_ex_live = flags[1] & ~flags[2];
            4'b1001: cond_ex_live = ~flags[1] | flags[2];
            4'b1010: cond_ex_live = (flags[3] == flags[0]);
            4'b1011: cond_ex_live = (flags[3] != flags[0]);
            4'b1100: cond_ex_live = ~flags[2] & (flags[3] == flags[0]);
            4'b1101: cond_ex_live = flags[2] | (flags[3] != flags[0]);
            4'b1110: cond_ex_live = 1'b1;
            default: cond_ex_live = 1'b0;
        endcase
    end

    // ALUWB must judge the condition on the flags that existed before this
    // instruction's own flag write, so it uses the copy captured in EXEC.
    assign cond_ex = (state == S_ALUWB) ? cond_q : cond_ex_live;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_FETCH;
            flags  <= 4'b0000;
            cond_q <= 1'b0;
        end else begin
            state <= state_next;
            if (state == S_EXECR || state == S_EXECI) begin
                cond_q <= cond_ex_live;
                if (funct[0] && cond_ex_live && cmd_ok) begin
                    if (cmd_arith) flags <= ALUFlags;
                    else           flags[3:2] <= ALUFlags[3:2];
                end
            end
        end
    end

    assign state_eff = reset ? S_FETCH : state;

    // NOTE: every output is given a default before the case so no path
    // leaves a variable unassigned, which would infer a latch.
    always_comb begin
        state_next = S_FETCH;
        PCWrite    = 1'b0;
        MemWrite   = 1'b0;
        RegWrite   = 1'b0;
        IRWrite    = 1'b0;
        LinkWrite  = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ALUControl = 2'b00;
        ResultSrc  = 2'b00;
        unique case (state_eff)
            S_FETCH: begin
                IRWrite    = 1'b1;
                PCWrite    = 1'b1;
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                ResultSrc  = 2'b10;
                state_next = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                unique case (op)
                    2'b01:   state_next = S_MEMADR;
                    2'b00:   state_next = funct[5] ? S_EXECI : S_EXECR;
                    2'b10:   state_next = funct[4] ? S_LINK : S_BRANCH;
                    default: state_next = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                ALUSrcB    = 2'b01;
                state_next = funct[0] ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                AdrSrc     = 1'b1;
                state_next = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = cond_ex;
            end
            S_MEMWR: begin
                AdrSrc   = 1'b1;
                MemWrite = cond_ex;
            end
            S_EXECR, S_EXECI: begin
                ALUSrcB    = (state_eff == S_EXECI) ? 2'b01 : 2'b00;
                ALUControl = cmd_alu;
                state_next = S_ALUWB;
            end
            S_ALUWB: begin
                ALUControl = cmd_alu;
                RegWrite   = cond_ex & cmd_ok;
                PCWrite    = cond_ex & cmd_ok & (rd == 4'd15);
            end
            S_LINK: begin
                ResultSrc  = 2'b11;
                RegWrite   = cond_ex;
                LinkWrite  = 1'b1;
                state_next = S_BRANCH;
            end
            S_BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                PCWrite   = cond_ex;
            end
            default: state_next = S_FETCH;
        endcase
        if (reset) begin
            PCWrite   = 1'b0;
            MemWrite  = 1'b0;
            RegWrite  = 1'b0;
            IRWrite   = 1'b0;
            LinkWrite = 1'b0;
        end
    end

endmodule

// File: tb/tb_arm_mc_controller.sv
// Self-checking bench: per-instruction expected cycle plans derived from the
// instruction class and an abstract flags/condition model.
module tb_arm_mc_controller;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [19:0] Instr = '0;
    logic [3:0]  ALUFlags = '0;
    logic        PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA, LinkWrite;
    logic [1:0]  ALUSrcB, ALUControl, ResultSrc, ImmSrc, RegSrc;

    arm_mc_controller dut (
        .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
        .PCWrite(PCWrite), .MemWrite(MemWrite), .RegWrite(RegWrite),
        .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .ResultSrc(ResultSrc),
        .ImmSrc(ImmSrc), .RegSrc(RegSrc), .LinkWrite(LinkWrite)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pcw, mw, rw, irw, lw, adr, srca;
        logic [1:0] srcb, aluc, res, imm, regsrc;
    } out_t;

    typedef struct {
        out_t e;
        out_t c;
        int   fk;   // 0 no flag write, 1 all flags, 2 N/Z only
    } step_t;

    step_t      plan[$];
    logic [3:0] flags_m = 4'b0000;
    logic       fixed_en = 1'b0;
    logic [3:0] fixed_val = 4'b0000;
    int         tests = 0;
    int         fails = 0;

    function automatic logic cond_holds(input logic [3:0] cond, input logic [3:0] f);
        logic n, z, c, v, base;
        n = f[3]; z = f[2]; c = f[1]; v = f[0];
        case (cond[3:1])
            3'd0: base = z;
            3'd1: base = c;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = c & ~z;
            3'd5: base = (n == v);
            3'd6: base = ~z & (n == v);
            default: base = 1'b1;
        endcase
        if (cond[3:1] == 3'd7) return ~cond[0];
        return base ^ cond[0];
    endfunction

    function automatic out_t obs_now();
        out_t o;
        o = '{PCWrite, MemWrite, RegWrite, IRWrite, LinkWrite, AdrSrc, ALUSrcA,
              ALUSrcB, ALUControl, ResultSrc, ImmSrc, RegSrc};
        return o;
    endfunction

    // Enables and ImmSrc/RegSrc are always checked; selects only where defined.
    function automatic void base_of(input logic [31:0] ins, output out_t e, output out_t c);
        logic [1:0] op;
        op = ins[27:26];
        e = '0;
        c = '0;
        {c.pcw, c.mw, c.rw, c.irw, c.lw} = 5'b11111;
        e.imm = op;
        c.imm = 2'b11;
        e.regsrc = {op == 2'b01, op == 2'b10};
        c.regsrc = 2'b11;
    endfunction

    function automatic void fetch_sel(inout out_t e, inout out_t c);
        e.adr = 1'b0;    c.adr = 1'b1;
        e.srca = 1'b1;   c.srca = 1'b1;
        e.srcb = 2'd2;   c.srcb = 2'b11;
        e.aluc = 2'd0;   c.aluc = 2'b11;
        e.res = 2'd2;    c.res = 2'b11;
    endfunction

    function automatic void build(input logic [31:0] ins);
        out_t       e, c;
        logic [1:0] op;
        logic [5:0] funct;
        logic [3:0] cmd;
        logic       ok, sup, arith;
        int         aluc;
        op = ins[27:26];
        funct = ins[25:20];
        cmd = funct[4:1];
        ok = cond_holds(ins[31:28], flags_m);
        plan.delete();

        base_of(ins, e, c);
        fetch_sel(e, c);
        e.pcw = 1'b1;
        e.irw = 1'b1;
        plan.push_back('{e, c, 0});

        base_of(ins, e, c);
        e.srca = 1'b1;  c.srca = 1'b1;
        e.srcb = 2'd2;  c.srcb = 2'b11;
        e.aluc = 2'd0;  c.aluc = 2'b11;
        e.res = 2'd2;   c.res = 2'b11;
        plan.push_back('{e, c, 0});

        if (op == 2'b01) begin
            base_of(ins, e, c);
            e.srca = 1'b0;  c.srca = 1'b1;
            e.srcb = 2'd1;  c.srcb = 2'b11;
            e.aluc = 2'd0;  c.aluc = 2'b11;
            plan.push_back('{e, c, 0});
            base_of(ins, e, c);
            e.adr = 1'b1;   c.adr = 1'b1;
            if (funct[0]) begin
                plan.push_back('{e, c, 0});
                base_of(ins, e, c);
                e.res = 2'd1;   c.res = 2'b11;
                e.rw = ok;
            end else begin
                e.mw = ok;
            end
            plan.push_back('{e, c, 0});
        end else if (op == 2'b00) begin
            case (cmd)
                4'b0100: begin aluc = 0; sup = 1'b1; arith = 1'b1; end
                4'b0010: begin aluc = 1; sup = 1'b1; arith = 1'b1; end
                4'b0000: begin aluc = 2; sup = 1'b1; arith = 1'b0; end
                4'b1100: begin aluc = 3; sup = 1'b1; arith = 1'b0; end
                default: begin aluc = 0; sup = 1'b0; arith = 1'b0; end
            endcase
            base_of(ins, e, c);
            e.srca = 1'b0;  c.srca = 1'b1;
            e.srcb = funct[5] ? 2'd1 : 2'd0;  c.srcb = 2'b11;
            if (sup) begin e.aluc = 2'(aluc); c.aluc = 2'b11; end
            plan.push_back('{e, c, (funct[0] && ok && sup) ? (arith ? 1 : 2) : 0});
            base_of(ins, e, c);
            e.res = 2'd0;   c.res = 2'b11;
            e.rw = ok && sup;
            e.pcw = ok && sup && (ins[15:12] == 4'd15);
            plan.push_back('{e, c, 0});
        end else if (op == 2'b10) begin
            if (funct[4]) begin
                base_of(ins, e, c);
                e.res = 2'd3;   c.res = 2'b11;
                e.rw = ok;
                e.lw = 1'b1;
                plan.push_back('{e, c, 0});
            end
            base_of(ins, e, c);
            e.srca = 1'b0;  c.srca = 1'b1;
            e.srcb = 2'd1;  c.srcb = 2'b11;
            e.aluc = 2'd0;  c.aluc = 2'b11;
            e.res = 2'd2;   c.res = 2'b11;
            e.pcw = ok;
            plan.push_back('{e, c, 0});
        end
    endfunction

    // Executes one instruction cycle by cycle against its plan. abort_at >= 0
    // asserts reset in that cycle instead and checks the reset outputs.
    task automatic run_instr(input logic [31:0] ins, input string tag, input int abort_at);
        out_t obs, e, c;
        int   n;
        build(ins);
        n = plan.size();
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            ALUFlags = fixed_en ? fixed_val : 4'($urandom);
            Instr = ins[31:12];
            if (k == abort_at) begin
                reset = 1'b1;
                #1;
                base_of(ins, e, c);
                fetch_sel(e, c);
                obs = obs_now();
                tests++;
                if ((obs & c) !== (e & c)) begin
                    fails++;
                    $display("FAIL %s reset-cycle %0d: got %h expected %h care %h", tag, k, obs, e, c);
                end
                flags_m = 4'b0000;
                break;
            end
            reset = 1'b0;
            #1;
            obs = obs_now();
            e = plan[k].e;
            c = plan[k].c;
            tests++;
            if ((obs & c) !== (e & c)) begin
                fails++;
                $display("FAIL %s cycle %0d: got %h expected %h care %h", tag, k, obs, e, c);
            end
            if (plan[k].fk == 1) flags_m = ALUFlags;
            else if (plan[k].fk == 2) flags_m[3:2] = ALUFlags[3:2];
        end
    endtask

    task automatic test_reset();
        out_t obs, e, c;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            reset = 1'b1;
            Instr = 20'hE0812;
            ALUFlags = 4'($urandom);
            #1;
            base_of(32'hE0812002, e, c);
            fetch_sel(e, c);
            obs = obs_now();
            tests++;
            if ((obs & c) !== (e & c)) begin
                fails++;
                $display("FAIL reset cycle %0d: got %h expected %h care %h", i, obs, e, c);
            end
        end
        flags_m = 4'b0000;
    endtask

    task automatic test_dp();
        for (int i = 0; i < 3; i++) run_instr(32'hE0812002, "add", -1);
        run_instr(32'hE2812005, "add_imm", -1);
        run_instr(32'hE081F002, "add_pc", -1);
        run_instr(32'hE0A12002, "unsupported", -1);
    endtask

    task automatic test_ldr_str();
        run_instr(32'hE5912000, "ldr", -1);
        run_instr(32'hE5812000, "str", -1);
    endtask

    task automatic test_bl();
        run_instr(32'hEB000002, "bl", -1);
        run_instr(32'hEA000002, "b", -1);
        run_instr(32'hEC000000, "op11", -1);
    endtask

    task automatic test_beq(input logic [3:0] alu_flags, input string tag);
        fixed_en = 1'b1;
        fixed_val = alu_flags;
        run_instr(32'hE0521001, {tag, "_subs"}, -1);
        fixed_en = 1'b0;
        run_instr(32'h0A000001, {tag, "_beq"}, -1);
        run_instr(32'hE0812002, {tag, "_after"}, -1);
    endtask

    task automatic test_never();
        run_instr(32'hF0812002, "never_dp", -1);
        run_instr(32'hF5812000, "never_str", -1);
        run_instr(32'hFB000002, "never_bl", -1);
    endtask

    task automatic test_reset_mid();
        fixed_en = 1'b1;
        fixed_val = 4'b0100;
        run_instr(32'hE0521001, "pre_subs", -1);
        fixed_en = 1'b0;
        run_instr(32'hE5812000, "str_abort", 3);
        run_instr(32'h0A000001, "post_beq", -1);
        run_instr(32'h1A000001, "post_bne", -1);
    endtask

    task automatic test_random();
        logic [31:0] ins;
        logic [3:0]  cmds [4];
        logic [5:0]  funct;
        logic [3:0]  rd;
        cmds = '{4'b0100, 4'b0010, 4'b0000, 4'b1100};
        for (int i = 0; i < 250; i++) begin
            funct = 6'($urandom);
            if (($urandom % 4) != 0) funct[4:1] = cmds[$urandom % 4];
            rd = (($urandom % 5) == 0) ? 4'd15 : 4'($urandom);
            ins = {4'($urandom), 2'($urandom), funct, 4'($urandom), rd, 12'($urandom)};
            run_instr(ins, "random", -1);
        end
        run_instr(32'hE0812002, "tail", -1);
    endtask

    initial begin
        test_reset();
        test_dp();
        test_ldr_str();
        test_bl();
        test_beq(4'b0100, "taken");
        test_beq(4'b0000, "nottaken");
        test_never();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/arm_mc_controller.md
# arm_mc_controller

Multicycle control unit for the ARM datapath. It decodes the fetched instruction, holds the condition flags, and drives every datapath enable and mux select through a fixed state sequence. It supports data processing (ADD/SUB/AND/ORR), LDR/STR, B and BL. BL writes the return address into R14. The block sits between the instruction register and the shared-memory multicycle datapath.

## Interface
Parameters: none.

Ports:
- clk  in  1  system clock; all state changes on its rising edge
- reset  in  1  synchronous, active-high
- Instr  in  20  Instr[31:12] from the instruction register: Cond[31:28], Op[27:26], Funct[25:20], Rd[15:12]
- ALUFlags  in  4  {N,Z,C,V} from the ALU, current cycle
- PCWrite  out  1  PC register enable
- MemWrite  out  1  memory write enable
- RegWrite  out  1  register file write enable
- IRWrite  out  1  instruction register enable
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut
- ALUSrcA  out  1  ALU A select: 0 = reg A, 1 = PC
- ALUSrcB  out  2  ALU B select: 00 = reg WD, 01 = ExtImm, 10 = constant 4
- ALUControl  out  2  00 = add, 01 = sub, 10 = and, 11 = orr
- ResultSrc  out  2  Result select: 00 = ALUOut, 01 = Data, 10 = ALUResult, 11 = PC
- ImmSrc  out  2  equals Op
- RegSrc  out  2  [0] = 1 makes RA1 R15 (branch); [1] = 1 makes RA2 Rd (STR)
- LinkWrite  out  1  forces register file WA3 to 14

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, LINK, BRANCH.
- FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=1, ALUSrcB=10, add, ResultSrc=10, PCWrite=1. Next state is DECODE.
- DECODE: ALUSrcA=1, ALUSrcB=10, add, ResultSrc=10, so R15 reads PC+8. Next state depends on Op:
  - Op=01: MEMADR.
  - Op=00: EXECI if Funct[5]=1, else EXECR.
  - Op=10: LINK if Funct[4]=1, else BRANCH.
  - Op=11: FETCH, with no writes.
- MEMADR: ALUSrcA=0, ALUSrcB=01, add. Next state is MEMRD if Funct[0]=1, else MEMWR.
- MEMRD: AdrSrc=1. Next state is MEMWB.
- MEMWB: ResultSrc=01, RegWrite. Next state is FETCH.
- MEMWR: AdrSrc=1, MemWrite. Next state is FETCH.
- EXECR / EXECI: ALUSrcA=0, ALUSrcB=00 / 01. Next state is ALUWB.
- ALUCmd=Funct[4:1] maps to ALUControl as follows: 0100 → add, 0010 → sub, 0000 → and, 1100 → orr. Any other cmd is unsupported.
- ALUWB: ResultSrc=00, RegWrite. If Rd=15, PCWrite is also asserted (result to PC). Next state is FETCH.
- LINK: ResultSrc=11, RegWrite, LinkWrite. PC already holds BL address+4. Next state is BRANCH.
- BRANCH: ALUSrcA=0, ALUSrcB=01, add, ResultSrc=10, PCWrite. Next state is FETCH.
- RegSrc is 01 when Op=10, 10 when Op=01, and 00 otherwise.
- CondEx from Cond and the internal Flags: EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL as in ARM. 1111 is never.
- Gating when CondEx=0 (condition failed):
  - RegWrite, MemWrite and non-FETCH PCWrite are gated to 0.
  - The state walk is unchanged.
  - FETCH IRWrite/PCWrite are never gated.
- An unsupported cmd also gates RegWrite/PCWrite in ALUWB.
- Flags register (4 bits) is written at the end of EXECR/EXECI when Funct[0]=1 and CondEx=1:
  - ADD/SUB write all four flags {N,Z,C,V}.
  - AND/ORR write N,Z only; C,V hold.

## Timing
- Reset: state=FETCH and Flags=0000. While reset=1, all enables (PCWrite, MemWrite, RegWrite, IRWrite, LinkWrite) are forced to 0. Selects take their FETCH values.
- First FETCH occurs in the cycle after reset deasserts.
- Outputs are Moore (decoded from state). The only exceptions are the CondEx/Rd/Funct gating, which is combinational from the registered IR and Flags.
- Cycles per instruction: LDR 5, STR 4, DP 4, B 3, BL 4, Op=11 2.
- CondEx uses Flags as they stand before the current instruction's flag write.
- Reset asserted mid-instruction: the state returns to FETCH on that edge and no enable is asserted in that cycle. Partially completed effects (for example a fetched PC) persist.

## Test plan
- Reset for 2 cycles, then hold Instr=E0812002 (ADD R2,R1,R2):
  - Enables are 0 during reset.
  - States run FETCH→DECODE→EXECR→ALUWB.
  - RegWrite=1 only in ALUWB, ALUControl=00, and IRWrite pulses once per 4 cycles.
- E5912000 (LDR): states run MEMADR→MEMRD→MEMWB with AdrSrc=1 in MEMRD and ResultSrc=01 with RegWrite in MEMWB (5 cycles). E5812000 (STR): MemWrite=1 for exactly one cycle with RegSrc=10.
- EB000002 (BL):
  - LINK asserts RegWrite, LinkWrite and ResultSrc=11.
  - BRANCH asserts PCWrite with ResultSrc=10.
  - Total 4 cycles.
- E0521001 (SUBS R1,R2,R1) with ALUFlags=0100, followed by 0A000001 (BEQ): Flags become 0100, then the BEQ BRANCH state asserts PCWrite=1.
- Repeat the previous case with ALUFlags=0000: the BEQ BRANCH state keeps PCWrite=0 and the next FETCH follows normally. F0812002 (Cond=1111): RegWrite stays 0 throughout.
- Assert reset during MEMWR of an STR: MemWrite=0 in that cycle, the state is FETCH next, and Flags=0000.
